// File: rtl/vec_irq_arbiter.sv
// Vectored-interrupt arbiter: selects one eligible requester by BR level, presents its vector
// to the CPU and returns a one-cycle iack to the granted device. Optional macro INTARB_RR_EN.
module vec_irq_arbiter #(
  parameter int unsigned          NREQ     = 4,
  parameter logic [9*NREQ-1:0]    VEC_LIST = {9'o064, 9'o060, 9'o100, 9'o104},
  parameter logic [3*NREQ-1:0]    BR_LIST  = {3'd4, 3'd4, 3'd6, 3'd6}
) (
  input  logic            clk_p,
  input  logic            sys_init_n,
  input  logic [NREQ-1:0] irq_i,
  output logic [NREQ-1:0] iack_o,
  input  logic [2:0]      cpu_pri,
  output logic            cpu_irq,
  output logic [8:0]      cpu_ivec,
  input  logic            cpu_iack,
  output logic [2:0]      grant_idx
);

  localparam int unsigned IW = 3;
  localparam int unsigned VW = 9;
  localparam int unsigned BW = 3;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK, S_GAP} state_e;

  state_e          state_q, state_d;
  logic            cpu_irq_q, cpu_irq_d;
  logic [VW-1:0]   cpu_ivec_q, cpu_ivec_d;
  logic [NREQ-1:0] iack_q, iack_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;

  logic [NREQ-1:0] elig;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [BW-1:0]   win_br;
  logic [VW-1:0]   win_vec;
  logic            gnt_elig;
  logic [NREQ-1:0] gnt_onehot;
  logic [IW-1:0]   start_c;
  int unsigned     n;

`ifdef INTARB_RR_EN
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  assign start_c = rr_ptr_q;
`else
  assign start_c = '0;
`endif

  // Strict comparison: a BR equal to the CPU priority is masked.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = irq_i[i] & (BR_LIST[BW*i +: BW] > cpu_pri);
    end
  end

  // Search from start_c with wrap; only a strictly higher BR displaces an earlier hit.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_br    = '0;
    win_vec   = '0;
    n         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      n = 32'(start_c) + k;
      if (n >= NREQ) n = n - NREQ;
      if (elig[n] && (!win_found || (BR_LIST[BW*n +: BW] > win_br))) begin
        win_found = 1'b1;
        win_idx   = IW'(n);
        win_br    = BR_LIST[BW*n +: BW];
        win_vec   = VEC_LIST[VW*n +: VW];
      end
    end
  end

  always_comb begin
    gnt_elig   = 1'b0;
    gnt_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gnt_onehot[i] = (grant_idx_q == IW'(i));
      if (grant_idx_q == IW'(i)) gnt_elig = elig[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cpu_irq_d   = cpu_irq_q;
    cpu_ivec_d  = cpu_ivec_q;
    iack_d      = iack_q;
    grant_idx_d = grant_idx_q;
`ifdef INTARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_idx_d = win_idx;
          cpu_irq_d   = 1'b1;
          cpu_ivec_d  = win_vec;
          state_d     = S_GRANT;
        end
      end
      // Grant is frozen here; an acknowledge beats a simultaneous withdrawal.
      S_GRANT: begin
        if (cpu_iack) begin
          cpu_irq_d = 1'b0;
          iack_d    = gnt_onehot;
          state_d   = S_ACK;
`ifdef INTARB_RR_EN
          rr_ptr_d  = (grant_idx_q == IW'(NREQ-1)) ? '0 : grant_idx_q + IW'(1);
`endif
        end else if (!gnt_elig) begin
          cpu_irq_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_ACK: begin
        iack_d  = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_p or negedge sys_init_n) begin
    if (!sys_init_n) begin
      state_q     <= S_IDLE;
      cpu_irq_q   <= 1'b0;
      cpu_ivec_q  <= '0;
      iack_q      <= '0;
      grant_idx_q <= '0;
`ifdef INTARB_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cpu_irq_q   <= cpu_irq_d;
      cpu_ivec_q  <= cpu_ivec_d;
      iack_q      <= iack_d;
      grant_idx_q <= grant_idx_d;
`ifdef INTARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign cpu_irq   = cpu_irq_q;
  assign cpu_ivec  = cpu_ivec_q;
  assign iack_o    = iack_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_vec_irq_arbiter.sv
// Self-checking bench for vec_irq_arbiter: directed scenarios plus randomized transactions
// checked against a BR-table reference model.
module tb_vec_irq_arbiter;

  logic       clk_p = 1'b0;
  logic       sys_init_n;
  logic [3:0] irq_i;
  logic [3:0] iack_o;
  logic [2:0] cpu_pri;
  logic       cpu_irq;
  logic [8:0] cpu_ivec;
  logic       cpu_iack;
  logic [2:0] grant_idx;

  int checks   = 0;
  int failures = 0;

  int br_tab  [4] = '{6, 6, 4, 4};
  int vec_tab [4] = '{9'o104, 9'o100, 9'o060, 9'o064};
  int rr = 0;

  vec_irq_arbiter dut (
    .clk_p     (clk_p),
    .sys_init_n(sys_init_n),
    .irq_i     (irq_i),
    .iack_o    (iack_o),
    .cpu_pri   (cpu_pri),
    .cpu_irq   (cpu_irq),
    .cpu_ivec  (cpu_ivec),
    .cpu_iack  (cpu_iack),
    .grant_idx (grant_idx)
  );

  always #5 clk_p = ~clk_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  // Highest eligible BR, then the first slot of that BR in search order (from rr when enabled).
  function automatic int model_win(input logic [3:0] irq, input logic [2:0] pri, input int start);
    int top = -1;
    for (int s = 0; s < 4; s++)
      if (irq[s] && br_tab[s] > int'(pri) && br_tab[s] > top) top = br_tab[s];
    if (top < 0) return -1;
    for (int k = 0; k < 4; k++) begin
      int s = (start + k) % 4;
      if (irq[s] && br_tab[s] == top) return s;
    end
    return -1;
  endfunction

  function automatic int rr_start();
`ifdef INTARB_RR_EN
    return rr;
`else
    return 0;
`endif
  endfunction

  // From GRANT: ack, then ACK and GAP cycles, ending in IDLE with irq_i cleared.
  task automatic do_ack(input int w, input string tag);
    cpu_iack = 1'b1;
    tick();
    chk({tag, "_iack"}, 32'(iack_o), 32'(4'b0001 << w));
    chk({tag, "_irq_drop"}, 32'(cpu_irq), 0);
    rr = (w + 1) % 4;
    cpu_iack = 1'b0;
    irq_i = 4'b0000;
    tick();
    chk({tag, "_iack_gone"}, 32'(iack_o), 0);
    tick();
    chk({tag, "_gap_idle"}, 32'(cpu_irq), 0);
  endtask

  initial begin
    int w;
    sys_init_n = 1'b0;
    irq_i      = 4'b1111;
    cpu_pri    = 3'd0;
    cpu_iack   = 1'b0;

    // Reset held with all requests active
    repeat (3) tick();
    chk("rst_irq", 32'(cpu_irq), 0);
    chk("rst_iack", 32'(iack_o), 0);
    chk("rst_ivec", 32'(cpu_ivec), 0);
    chk("rst_gidx", 32'(grant_idx), 0);
    @(negedge clk_p);
    sys_init_n = 1'b1;
    tick();
    w = model_win(4'b1111, 3'd0, rr_start());
    chk("rel_irq", 32'(cpu_irq), 1);
    chk("rel_ivec", 32'(cpu_ivec), 32'(vec_tab[w]));
    chk("rel_gidx", 32'(grant_idx), 32'(w));
    do_ack(w, "rel");

    // Masking: BR6 masked by pri 6, unmasked by pri 5
    cpu_pri = 3'd6;
    irq_i   = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mask_irq", 32'(cpu_irq), 0);
    end
    cpu_pri = 3'd5;
    tick();
    chk("unmask_irq", 32'(cpu_irq), 1);
    chk("unmask_ivec", 32'(cpu_ivec), 32'(9'o104));
    // Withdrawal by raising priority, then stray cpu_iack in IDLE
    cpu_pri = 3'd6;
    tick();
    chk("pri_wd_irq", 32'(cpu_irq), 0);
    chk("pri_wd_iack", 32'(iack_o), 0);
    cpu_iack = 1'b1;
    tick();
    chk("stray_iack", 32'(iack_o), 0);
    cpu_iack = 1'b0;
    irq_i    = 4'b0000;
    cpu_pri  = 3'd0;
    tick();
    chk("stray_iack2", 32'(iack_o), 0);

    // Priority and freeze: BR6 slot0 over BR4 slot3, then slot3 after GAP
    irq_i = 4'b1001;
    tick();
    chk("prio_ivec", 32'(cpu_ivec), 32'(9'o104));
    cpu_iack = 1'b1;
    tick();
    chk("prio_iack", 32'(iack_o), 32'(4'b0001));
    rr = 1;
    cpu_iack = 1'b0;
    irq_i    = 4'b1000;
    tick();
    chk("prio_ack_end", 32'(iack_o), 0);
    tick();
    chk("prio_gap", 32'(cpu_irq), 0);
    tick();
    chk("prio2_irq", 32'(cpu_irq), 1);
    chk("prio2_ivec", 32'(cpu_ivec), 32'(9'o064));
    irq_i = 4'b1001;
    tick();
    chk("freeze_ivec", 32'(cpu_ivec), 32'(9'o064));
    chk("freeze_gidx", 32'(grant_idx), 3);
    do_ack(3, "freeze");

    // Withdrawal of slot2 by irq drop; later cpu_iack has no effect
    irq_i = 4'b0100;
    tick();
    chk("wd_ivec", 32'(cpu_ivec), 32'(9'o060));
    irq_i = 4'b0000;
    tick();
    chk("wd_irq", 32'(cpu_irq), 0);
    chk("wd_iack", 32'(iack_o), 0);
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
    chk("wd_late_iack", 32'(iack_o), 0);
    tick();
    chk("wd_late_iack2", 32'(iack_o), 0);

    // Simultaneous withdrawal and acknowledge: acknowledge wins
    irq_i = 4'b0100;
    tick();
    irq_i    = 4'b0000;
    do_ack(2, "race");

    // Same-BR tie held across several grants
    for (int g = 0; g < 4; g++) begin
      irq_i = 4'b0011;
      tick();
      w = model_win(4'b0011, 3'd0, rr_start());
      chk("tie_gidx", 32'(grant_idx), 32'(w));
      do_ack(w, "tie");
    end

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      logic [3:0] r_irq;
      logic [2:0] r_pri;
      r_irq   = 4'($urandom_range(0, 15));
      r_pri   = 3'($urandom_range(0, 7));
      irq_i   = r_irq;
      cpu_pri = r_pri;
      tick();
      w = model_win(r_irq, r_pri, rr_start());
      if (w < 0) begin
        chk("rnd_idle", 32'(cpu_irq), 0);
        irq_i = 4'b0000;
        tick();
        chk("rnd_idle2", 32'(cpu_irq), 0);
      end else begin
        chk("rnd_irq", 32'(cpu_irq), 1);
        chk("rnd_ivec", 32'(cpu_ivec), 32'(vec_tab[w]));
        chk("rnd_gidx", 32'(grant_idx), 32'(w));
        for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
          irq_i = 4'($urandom_range(0, 15)) | (4'b0001 << w);
          tick();
          chk("rnd_hold_ivec", 32'(cpu_ivec), 32'(vec_tab[w]));
          chk("rnd_hold_irq", 32'(cpu_irq), 1);
        end
        if ($urandom_range(0, 3) != 0) begin
          do_ack(w, "rnd_ack");
        end else begin
          irq_i = irq_i & ~(4'b0001 << w);
          tick();
          chk("rnd_wd_irq", 32'(cpu_irq), 0);
          chk("rnd_wd_iack", 32'(iack_o), 0);
          irq_i = 4'b0000;
        end
      end
    end

    // Mid-operation reset drops outputs immediately
    cpu_pri = 3'd0;
    irq_i   = 4'b0010;
    tick();
    cpu_iack = 1'b1;
    tick();
    #1 sys_init_n = 1'b0;
    #1;
    chk("midrst_iack", 32'(iack_o), 0);
    chk("midrst_irq", 32'(cpu_irq), 0);
    cpu_iack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
